// File: rtl/s9234_par_frame_tx.sv
// Parity-framed serial word transmitter (start, DATA_W bits LSB first, parity, stop); PAR_FRAME_TX_ERR_INJECT_EN adds err_inj to corrupt the sent parity bit.
// Latency: line goes low the cycle after accept; backpressure: tx_ready is high only while idle, so one word is in flight at a time.
module s9234_par_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int ODD_PAR      = 0,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              CK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
`ifdef PAR_FRAME_TX_ERR_INJECT_EN
    input  logic              err_inj,
`endif
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              frame_done,
    output logic              par_bit
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [BW-1:0]     bit_idx, bit_nxt;
    logic              stop_idx, stop_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              inj_q, inj_nxt;
    logic              line_nxt, ready_nxt, busy_nxt, done_nxt, par_nxt;
    logic              bit_end;
    logic              par_new;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
    assign par_new = (^tx_data) ^ (ODD_PAR != 0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        stop_nxt  = stop_idx;
        shreg_nxt = shreg;
        inj_nxt   = inj_q;
        line_nxt  = tx_line;
        ready_nxt = tx_ready;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        par_nxt   = par_bit;

        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_nxt = tx_data;
                    par_nxt   = par_new;
`ifdef PAR_FRAME_TX_ERR_INJECT_EN
                    inj_nxt   = err_inj;
`else
                    inj_nxt   = 1'b0;
`endif
                    state_nxt = START;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    stop_nxt  = 1'b0;
                    line_nxt  = 1'b0;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    line_nxt  = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_idx == BW'(DATA_W - 1)) begin
                        state_nxt = PARITY;
                        line_nxt  = par_bit ^ inj_q;
                    end else begin
                        bit_nxt  = bit_idx + 1'b1;
                        line_nxt = shreg_nxt[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    line_nxt  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // each stop bit is a full bit period; the last one returns to idle
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        ready_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                line_nxt  = 1'b1;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            inj_q      <= 1'b0;
            tx_line    <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            stop_idx   <= stop_nxt;
            shreg      <= shreg_nxt;
            inj_q      <= inj_nxt;
            tx_line    <= line_nxt;
            tx_ready   <= ready_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            par_bit    <= par_nxt;
        end
    end

endmodule

// File: doc/s9234_par_frame_tx.md
Name: s9234_par_frame_tx

Overview:
- Serial parity-framed word transmitter.
- Takes a parallel data word through a valid/ready handshake and computes its parity bit.
- Shifts out start bit, data (LSB first), parity bit and stop bit(s) on a single line.
- Transmit end for the existing 8-bit parity-check/compare cone: it produces the data-plus-parity stream that cone checks.

Parameters:
DATA_W, 8, payload width in bits (>=1)
ODD_PAR, 0, 0 = even parity (data ^ parity has even ones), 1 = odd parity
CLKS_PER_BIT, 4, CK cycles per serial bit (>=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
CK  input  1  clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
tx_data  input  DATA_W  word to send; sampled on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word
tx_line  output  1  serial output; idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after last stop bit
par_bit  output  1  parity bit of the last accepted word

Behaviour:
- Clock and reset: one clock CK; reset RST_N is asynchronous, active-low.
- Reset values: tx_line=1, tx_ready=1, busy=0, frame_done=0, par_bit=0, state=IDLE, all counters=0.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: occurs on the edge where tx_valid & tx_ready.
  - On that edge: shift reg <= tx_data; par_bit <= (^tx_data) ^ ODD_PAR; state <= START; tx_ready <= 0; busy <= 1.
- tx_ready is 1 only in IDLE.
  - tx_data and tx_valid are ignored while not ready.
  - tx_valid may drop without accept; nothing is stored.
- Bit timing: each state holds its line value for CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and then wraps.
  - A state advances on the edge where the counter = CLKS_PER_BIT-1.
- Line values per state:
  - START: tx_line=0.
  - DATA: tx_line = current shift reg LSB; DATA_W bits, index 0..DATA_W-1. The shift reg shifts right on each bit boundary; DATA exits after index DATA_W-1.
  - PARITY: tx_line = par_bit.
  - STOP: tx_line=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Latency: if accept is at edge T, tx_line goes 0 in the cycle after T.
- Frame length: (2+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles, ending with the return to IDLE.
- On the STOP->IDLE edge: frame_done <= 1 for exactly one cycle, tx_ready <= 1, busy <= 0.
- Back-to-back frames: a word presented during the frame_done cycle is accepted on that edge. The minimum inter-frame idle is one cycle of tx_line=1.
- par_bit holds its value until the next accept.
- Reset mid-frame: immediately forces the reset values. A partial frame is abandoned and the line is high.
- CLKS_PER_BIT=1: every state lasts one cycle (DATA lasts DATA_W cycles); no special casing.

Optional Feature:
- Macro: PAR_FRAME_TX_ERR_INJECT_EN.
- When defined:
  - Adds input err_inj (1 bit), sampled on accept.
  - If err_inj is 1 at accept, the transmitted PARITY bit is inverted for that frame only (deliberate parity error for checker test). par_bit still reports the true parity.
- When not defined:
  - The port is absent.
  - The PARITY bit always equals par_bit.

Test Plan:
- Reset then idle, no tx_valid for 20 cycles -> tx_line=1, tx_ready=1, busy=0, frame_done never 1.
- Defaults, send 0xA5 -> line 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each for 4 cycles; par_bit=0; frame_done pulses once 44 cycles after accept.
- ODD_PAR=1, send 0x01 -> par_bit=0, PARITY line=0; with ODD_PAR=0, send 0x01 -> par_bit=1, PARITY line=1.
- tx_valid held high with 0x3C then 0xFF -> second accept on the frame_done edge; exactly one cycle tx_line=1 between frames; 0xFF parity=0 (even).
- Assert RST_N=0 during DATA bit 3 of a frame -> tx_line=1 and tx_ready=1 immediately (asynchronous); no frame_done; next word sends a correct full frame.
- With PAR_FRAME_TX_ERR_INJECT_EN, send 0xA5 with err_inj=1 -> PARITY line=1 while par_bit=0; next frame with err_inj=0 -> PARITY line=0.
